// File: rtl/ram_march_bist_if.sv
// RAM-side port of the March BIST: write enable, address and write data out,
// combinational read data back.
interface ram_march_bist_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10
);
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport master (
    output ram_we,
    output ram_addr,
    output ram_din,
    input  ram_dout
  );

  modport slave (
    input  ram_we,
    input  ram_addr,
    input  ram_din,
    output ram_dout
  );
endinterface

// File: rtl/ram_march_bist.sv
// March BIST controller: W0 (up), R0W1 (up), R1W0 (down), R0 (up) over every
// address of a single-port async-read RAM, one cycle per address.
module ram_march_bist #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DW-1:0]     pattern,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [AW-1:0]     fail_addr,
  output logic [1:0]        fail_elem,
  ram_march_bist_if.master  ram
);

  typedef enum logic [2:0] {StIdle, StW0, StR0w1, StR1w0, StR0, StDone} state_e;

  localparam logic [AW-1:0] AddrMax = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] pat_q, pat_d;
  logic          fail_q, fail_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [1:0]    fail_elem_q, fail_elem_d;

  logic          we;
  logic [DW-1:0] din;
  logic          cmp_en;
  logic [DW-1:0] expect_data;
  logic [1:0]    elem;
  logic          asc_last;

  assign asc_last = (addr_q == AddrMax);

  // State, address counter, latched pattern and sticky failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      pat_q       <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pat_q       <= pat_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  // Next-state, RAM drive and read compare for the current march element.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pat_d       = pat_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    we          = 1'b0;
    din         = '0;
    cmp_en      = 1'b0;
    expect_data = '0;
    elem        = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StW0;
          pat_d       = pattern;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = 2'd0;
          addr_d      = '0;
        end
      end
      StW0: begin
        we  = 1'b1;
        din = pat_q;
        if (asc_last) begin
          state_d = StR0w1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StR0w1: begin
        // Async read still shows the old word while the new one is written.
        we          = 1'b1;
        din         = ~pat_q;
        cmp_en      = 1'b1;
        expect_data = pat_q;
        elem        = 2'd1;
        if (asc_last) begin
          state_d = StR1w0;
          addr_d  = AddrMax;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StR1w0: begin
        we          = 1'b1;
        din         = pat_q;
        cmp_en      = 1'b1;
        expect_data = ~pat_q;
        elem        = 2'd2;
        if (addr_q == '0) begin
          state_d = StR0;
          addr_d  = '0;
        end else begin
          addr_d = addr_q - 1'b1;
        end
      end
      StR0: begin
        cmp_en      = 1'b1;
        expect_data = pat_q;
        elem        = 2'd3;
        if (asc_last) begin
          state_d = StDone;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        addr_d  = '0;
      end
    endcase

    // Only the first mismatch of a run is recorded.
    if (cmp_en && (ram.ram_dout != expect_data) && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = addr_q;
      fail_elem_d = elem;
    end
  end

  assign busy         = (state_q == StW0) || (state_q == StR0w1) ||
                        (state_q == StR1w0) || (state_q == StR0);
  assign done         = (state_q == StDone);
  assign fail         = fail_q;
  assign fail_addr    = fail_addr_q;
  assign fail_elem    = fail_elem_q;
  assign ram.ram_we   = we;
  assign ram.ram_addr = addr_q;
  assign ram.ram_din  = din;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist with AW=4, DW=8: RAM model with optional planted
// faults, a per-cycle schedule monitor and a done-triggered scoreboard.
module tb_ram_march_bist;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  typedef struct {
    logic       fail;
    logic [3:0] addr;
    logic [1:0] elem;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] pattern = '0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [1:0]    fail_elem;

  logic [DW-1:0] mem [16];
  int            fault_mode = 0;

  int            n_vec = 0;
  int            n_bad = 0;
  int unsigned   edges = 0;
  int unsigned   acc_edge = 0;
  bit            run_active = 1'b0;
  logic [DW-1:0] exp_p = '0;
  int            busy_cnt = 0;
  int            we_cnt = 0;
  exp_t          sb [$];

  ram_march_bist_if #(.DW(DW), .AW(AW)) rif ();

  ram_march_bist #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .ram       (rif.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Good RAM plus planted faults: 1 = bit0 stuck at 0 at address 5,
  // 2 = reading 0x5A at address 9 returns 0x5B.
  always @(posedge clk) if (rif.ram_we) mem[rif.ram_addr] <= rif.ram_din;

  always_comb begin
    rif.ram_dout = mem[rif.ram_addr];
    if (fault_mode == 1 && rif.ram_addr == 4'd5) rif.ram_dout = mem[rif.ram_addr] & 8'hFE;
    if (fault_mode == 2 && rif.ram_addr == 4'd9 && mem[rif.ram_addr] == 8'h5A)
      rif.ram_dout = 8'h5B;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: sample mid-cycle; cycle 1 is the cycle after the accepting edge.
  always @(negedge clk) begin
    int         c;
    logic       ew;
    logic [3:0] ea;
    logic [7:0] ed;
    exp_t       e;
    if (run_active) begin
      c = int'(edges - acc_edge) + 1;
      if (c == 1) begin
        busy_cnt = 0;
        we_cnt   = 0;
      end
      if (busy) busy_cnt++;
      if (rif.ram_we) we_cnt++;
      if (c >= 1 && c <= 64) begin
        if (c <= 16) begin
          ew = 1'b1; ea = 4'(c - 1);  ed = exp_p;
        end else if (c <= 32) begin
          ew = 1'b1; ea = 4'(c - 17); ed = ~exp_p;
        end else if (c <= 48) begin
          ew = 1'b1; ea = 4'(48 - c); ed = exp_p;
        end else begin
          ew = 1'b0; ea = 4'(c - 49); ed = 8'h00;
        end
        check($sformatf("addr@%0d", c), 32'(rif.ram_addr), 32'(ea));
        check($sformatf("we@%0d", c), 32'(rif.ram_we), 32'(ew));
        check($sformatf("din@%0d", c), 32'(rif.ram_din), 32'(ed));
        check($sformatf("busy@%0d", c), 32'(busy), 32'd1);
      end else if (c == 65) begin
        check("done_at_65", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("we_in_done", 32'(rif.ram_we), 32'd0);
      end else if (c == 66 || c == 67) begin
        check($sformatf("busy_idle@%0d", c), 32'(busy), 32'd0);
        check($sformatf("done_idle@%0d", c), 32'(done), 32'd0);
        check($sformatf("we_idle@%0d", c), 32'(rif.ram_we), 32'd0);
      end
      if (done) begin
        check("done_cycle", 32'(c), 32'd65);
        check("busy_cycles", 32'(busy_cnt), 32'd64);
        check("write_cycles", 32'(we_cnt), 32'd48);
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("fail", 32'(fail), 32'(e.fail));
          check("fail_addr", 32'(fail_addr), 32'(e.addr));
          check("fail_elem", 32'(fail_elem), 32'(e.elem));
        end
      end
    end else begin
      check("done_unexpected", 32'(done), 32'd0);
    end
  end

  task automatic launch(input logic [7:0] p, input int fm, input bit push, input exp_t e);
    @(posedge clk);
    #1;
    fault_mode = fm;
    pattern    = p;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    acc_edge = edges;
    exp_p    = p;
    if (push) sb.push_back(e);
    run_active = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    check("run_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    run_active = 1'b0;
  endtask

  initial begin
    exp_t ok;
    ok.fail = 1'b0; ok.addr = 4'd0; ok.elem = 2'd0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    check("rst_fail_elem", 32'(fail_elem), 32'd0);
    check("rst_we", 32'(rif.ram_we), 32'd0);
    check("rst_addr", 32'(rif.ram_addr), 32'd0);
    check("rst_din", 32'(rif.ram_din), 32'd0);

    // Clean run, then RAM must hold the pattern everywhere.
    launch(8'h55, 0, 1'b1, ok);
    wait_done();
    for (int i = 0; i < 16; i++) check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'h55);

    // Clean run with 0xA5: 0x5A appears on ram_din only in R0W1.
    launch(8'hA5, 0, 1'b1, ok);
    wait_done();

    // Stuck-at-0 on bit0 at address 5, caught in R0W1.
    launch(8'h55, 1, 1'b1, '{fail: 1'b1, addr: 4'd5, elem: 2'd1});
    wait_done();

    // Fault seen only when reading ~P at address 9, caught in R1W0.
    launch(8'hA5, 2, 1'b1, '{fail: 1'b1, addr: 4'd9, elem: 2'd2});
    wait_done();

    // start during the run (cycle 20) and in DONE (cycle 65) must be ignored.
    launch(8'h55, 0, 1'b1, ok);
    repeat (19) @(posedge clk);
    #1;
    start   = 1'b1;
    pattern = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (44) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Reset in cycle 30 of a faulty run (fail already set), then a clean run.
    launch(8'h55, 1, 1'b0, ok);
    repeat (29) @(posedge clk);
    #1;
    rst        = 1'b1;
    run_active = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_we", 32'(rif.ram_we), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_fail", 32'(fail), 32'd0);
    launch(8'h55, 0, 1'b1, ok);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
